// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
// Shared 7-segment definitions for the display drivers (the legacy static
// per-digit decoder and the multiplexed scan driver).
//   - segment bit positions inside the 8-bit pattern {dp,g,f,e,d,c,b,a}
//   - active-high glyph constants for 0..9, a dash and an all-off pattern
//   - seg_glyph(): 4-bit code -> active-high glyph, dp bit left clear
// ---------------------------------------------------------------------------
package seg_disp_pkg;

    typedef logic [7:0] seg_pat_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam seg_pat_t SEG_0 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F));
    localparam seg_pat_t SEG_1 = seg_pat_t'((1 << SEG_B) | (1 << SEG_C));
    localparam seg_pat_t SEG_2 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_D) |
                                             (1 << SEG_E) | (1 << SEG_G));
    localparam seg_pat_t SEG_3 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_G));
    localparam seg_pat_t SEG_4 = seg_pat_t'((1 << SEG_B) | (1 << SEG_C) | (1 << SEG_F) |
                                             (1 << SEG_G));
    localparam seg_pat_t SEG_5 = seg_pat_t'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) |
                                             (1 << SEG_F) | (1 << SEG_G));
    localparam seg_pat_t SEG_6 = seg_pat_t'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) |
                                             (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));
    localparam seg_pat_t SEG_7 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C));
    localparam seg_pat_t SEG_8 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                             (1 << SEG_G));
    localparam seg_pat_t SEG_9 = seg_pat_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_F) | (1 << SEG_G));
    localparam seg_pat_t SEG_DASH = seg_pat_t'(1 << SEG_G);
    localparam seg_pat_t SEG_OFF  = 8'h00;

    // Non-decimal codes (A-F) render as a dash so a corrupted BCD digit is
    // visibly wrong rather than mistaken for a number.
    function automatic seg_pat_t seg_glyph(input logic [3:0] code);
        seg_pat_t pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_dec7.sv
// ---------------------------------------------------------------------------
// seg_dec7
// Combinational 7-segment decoder, active-high output.
//   code  in   4   digit code (0-9 glyph, A-F dash)
//   dp    in   1   decimal point request
//   seg   out  8   {dp,g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module seg_dec7
    import seg_disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg         = seg_glyph(code);
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_scan_disp.sv
// ---------------------------------------------------------------------------
// seg_scan_disp
// Time-multiplexed N-digit 7-segment scan driver. A BCD word plus decimal
// point and blink masks is captured on upd into a pending buffer and moved
// into the display buffer only at the frame boundary, so a frame is never
// torn. One digit is driven per slot of SCAN_DIV clocks; the first
// BLANK_CYC clocks of each slot keep all digit selects off to stop the
// previous digit's pattern ghosting onto the next one.
//
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   bcd_in      in   4*NUM_DIGITS  packed BCD, nibble i = digit i
//   dp_mask     in   NUM_DIGITS    decimal point on digit i
//   blink_mask  in   NUM_DIGITS    digit i blinks
//   lz_en       in   1             enable leading-zero blanking (live)
//   upd         in   1             strobe: capture bcd_in/dp_mask/blink_mask
//   seg         out  8             {dp,g,f,e,d,c,b,a}, registered
//   dig_sel     out  NUM_DIGITS    one-hot digit enable, registered
//   frame_done  out  1             pulse on last cycle of the last digit slot
// ---------------------------------------------------------------------------
module seg_scan_disp
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_KEEP      = 1,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    input  logic                    upd,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [7:0]            SEG_IDLE = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    // Scan position
    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] idx;
    logic             slot_last;
    logic             wrap;

    // Blink timing
    logic [BLK_W-1:0] blk_cnt;
    logic             blink_ph;

    // Pending and display buffers
    logic                    pend_flag;
    logic [4*NUM_DIGITS-1:0] pend_bcd;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blink;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blink;

    // Leading-zero mask
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;

    // Stage 0 (combinational from current scan position) and stage 1 (pins)
    logic [3:0]            code_p0;
    logic                  dp_p0;
    logic [7:0]            glyph_p0;
    logic                  hide_p0;
    logic [7:0]            pat_p0;
    logic [7:0]            seg_nxt_p0;
    logic [NUM_DIGITS-1:0] dig_on_p0;
    logic [NUM_DIGITS-1:0] dig_nxt_p0;
    logic [7:0]            seg_p1;
    logic [NUM_DIGITS-1:0] dig_sel_p1;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign wrap       = slot_last && (idx == IDX_LAST);
    assign frame_done = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt  <= '0;
            blink_ph <= 1'b0;
        end else if (wrap) begin
            if (blk_cnt == BLK_LAST) begin
                blk_cnt  <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                blk_cnt <= blk_cnt + BLK_W'(1);
            end
        end
    end

    // The display buffer only changes on the wrap edge. An upd landing in
    // the wrap cycle itself bypasses the pending buffer so it is not lost
    // for a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_flag  <= 1'b0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            disp_blink <= '0;
        end else begin
            if (upd) begin
                pend_bcd   <= bcd_in;
                pend_dp    <= dp_mask;
                pend_blink <= blink_mask;
            end
            if (wrap) begin
                pend_flag <= 1'b0;
                if (upd) begin
                    disp_bcd   <= bcd_in;
                    disp_dp    <= dp_mask;
                    disp_blink <= blink_mask;
                end else if (pend_flag) begin
                    disp_bcd   <= pend_bcd;
                    disp_dp    <= pend_dp;
                    disp_blink <= pend_blink;
                end
            end else if (upd) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every digit above it (and itself) is zero with no decimal point.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_bcd[4*i +: 4] == 4'd0) && !disp_dp[i];
            if (i >= LZ_KEEP) begin
                lz_blank[i] = lz_en && zero_run;
            end
        end
    end

    // ---- stage 0: decode the digit under the scan position ----
    always_comb begin
        code_p0 = disp_bcd[{idx, 2'b00} +: 4];
        dp_p0   = disp_dp[idx];
    end

    seg_dec7 u_dec (
        .code (code_p0),
        .dp   (dp_p0),
        .seg  (glyph_p0)
    );

    always_comb begin
        hide_p0    = lz_blank[idx] || (blink_ph && disp_blink[idx]);
        pat_p0     = hide_p0 ? SEG_OFF : glyph_p0;
        seg_nxt_p0 = (SEG_ACT_LOW != 0) ? ~pat_p0 : pat_p0;
        dig_on_p0  = (slot_cnt < BLANK_END) ? '0 : (NUM_DIGITS'(1) << idx);
        dig_nxt_p0 = (DIG_ACT_LOW != 0) ? ~dig_on_p0 : dig_on_p0;
    end

    // ---- stage 1: registered pin drivers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1     <= SEG_IDLE;
            dig_sel_p1 <= DIG_IDLE;
        end else begin
            seg_p1     <= seg_nxt_p0;
            dig_sel_p1 <= dig_nxt_p0;
        end
    end

    assign seg     = seg_p1;
    assign dig_sel = dig_sel_p1;

endmodule

// File: tb/tb_seg_scan_disp.sv
`timescale 1ns/1ps
module tb_seg_scan_disp;

    localparam int N      = 6;
    localparam int DIV    = 4;
    localparam int FRAME  = N * DIV;
    localparam int BLINKF = 2;

    logic          clk;
    logic          rst_n;
    logic [23:0]   bcd_in;
    logic [5:0]    dp_mask;
    logic [5:0]    blink_mask;
    logic          lz_en;
    logic          upd;
    logic [7:0]    seg;
    logic [5:0]    dig_sel;
    logic          frame_done;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: t = clock edges since reset release; display content per frame.
    int          t;
    logic [23:0] m_bcd, n_bcd;
    logic [5:0]  m_dp, n_dp, m_blk, n_blk;
    bit          have_new;

    seg_scan_disp #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (BLINKF),
        .LZ_KEEP      (1),
        .SEG_ACT_LOW  (1),
        .DIG_ACT_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .upd        (upd),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout t=%0d", t);
        $fatal(1);
    end

    function automatic logic [7:0] glyph_of(input logic [3:0] n);
        case (n)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h40;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0d", name, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_bcd    = '0;
        m_dp     = '0;
        m_blk    = '0;
        have_new = 0;
    endtask

    // One clock: predict outputs from the current scan position and inputs,
    // advance the model, clock the DUT and compare.
    task automatic step();
        int d, c, fr, ph;
        logic zr, hide;
        logic [7:0] pat, es;
        logic [5:0] ed;
        d  = (t % FRAME) / DIV;
        c  = t % DIV;
        fr = t / FRAME;
        ph = (fr / BLINKF) % 2;
        zr = 1'b1;
        for (int i = N - 1; i >= d; i--)
            if (m_bcd[4*i +: 4] != 4'd0 || m_dp[i]) zr = 1'b0;
        hide = (lz_en && d >= 1 && zr) || (ph == 1 && m_blk[d]);
        pat  = hide ? 8'h00 : (glyph_of(m_bcd[4*d +: 4]) | {m_dp[d], 7'b0});
        es   = ~pat;
        ed   = (c == 0) ? 6'h3F : ~(6'(1) << d);
        if (upd) begin
            n_bcd = bcd_in; n_dp = dp_mask; n_blk = blink_mask; have_new = 1;
        end
        t++;
        if (t % FRAME == 0 && have_new) begin
            m_bcd = n_bcd; m_dp = n_dp; m_blk = n_blk; have_new = 0;
        end
        @(posedge clk);
        #1;
        check("seg", {24'b0, seg}, {24'b0, es});
        check("dig_sel", {26'b0, dig_sel}, {26'b0, ed});
        check("frame_done", {31'b0, frame_done}, {31'b0, (t % FRAME) == FRAME - 1});
    endtask

    task automatic next_frame();
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (t % FRAME == 0) break;
        end
    endtask

    // Stop once the last modelled state was digit d, slot count c.
    task automatic run_to(input int d, input int c);
        for (int k = 0; k < FRAME; k++) begin
            step();
            if ((t - 1) % FRAME == DIV * d + c) break;
        end
    endtask

    task automatic do_upd(input logic [23:0] b, input logic [5:0] dp, input logic [5:0] bl);
        bcd_in = b; dp_mask = dp; blink_mask = bl; upd = 1'b1;
        step();
        upd = 1'b0;
    endtask

    initial begin
        int ph;
        rst_n = 1'b0; bcd_in = '0; dp_mask = '0; blink_mask = '0; lz_en = 1'b1; upd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", {24'b0, seg}, 32'hFF);
        check("rst_dig", {26'b0, dig_sel}, 32'h3F);
        check("rst_fd", {31'b0, frame_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_cyc1_dig", {26'b0, dig_sel}, 32'h3F);
        step();
        check("rel_cyc2_dig", {26'b0, dig_sel}, 32'h3E);
        check("rel_cyc2_seg", {24'b0, seg}, 32'hC0);

        // Number with leading zeros
        do_upd(24'h001234, 6'h00, 6'h00);
        next_frame();
        run_to(0, 2); check("n1234_d0", {24'b0, seg}, 32'h99);
        check("n1234_d0sel", {26'b0, dig_sel}, 32'h3E);
        run_to(3, 2); check("n1234_d3", {24'b0, seg}, 32'hF9);
        run_to(4, 2); check("n1234_d4", {24'b0, seg}, 32'hFF);
        run_to(5, 2); check("n1234_d5", {24'b0, seg}, 32'hFF);

        // Mid-frame update held until the wrap
        next_frame();
        run_to(2, 2);
        do_upd(24'h111111, 6'h00, 6'h00);
        run_to(4, 2); check("hold_old_d4", {24'b0, seg}, 32'hFF);
        run_to(4, 2); check("hold_new_d4", {24'b0, seg}, 32'hF9);

        // Non-BCD code and LZ on/off
        do_upd(24'h00000B, 6'h00, 6'h00);
        next_frame();
        run_to(0, 2); check("dash_d0", {24'b0, seg}, 32'hBF);
        run_to(1, 2); check("dash_lz_d1", {24'b0, seg}, 32'hFF);
        lz_en = 1'b0;
        run_to(2, 2); check("nolz_d2", {24'b0, seg}, 32'hC0);
        lz_en = 1'b1;

        // Blink on digit 0, digit 1 steady
        do_upd(24'h000015, 6'h00, 6'h01);
        next_frame();
        for (int f = 0; f < 4; f++) begin
            run_to(0, 2);
            ph = (((t - 1) / FRAME) / BLINKF) % 2;
            check("blink_d0", {24'b0, seg}, (ph == 1) ? 32'hFF : 32'h92);
            run_to(1, 2); check("steady_d1", {24'b0, seg}, 32'hF9);
            next_frame();
        end

        // Asynchronous reset in the middle of digit 3
        run_to(3, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", {24'b0, seg}, 32'hFF);
        check("arst_dig", {26'b0, dig_sel}, 32'h3F);
        check("arst_fd", {31'b0, frame_done}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_dig", {26'b0, dig_sel}, 32'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        check("rescan_dig", {26'b0, dig_sel}, 32'h3E);
        check("rescan_seg", {24'b0, seg}, 32'hC0);
        run_to(1, 2); check("rescan_d1", {24'b0, seg}, 32'hFF);

        // Randomized traffic
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 7) == 0) begin
                logic [23:0] r;
                r = 24'($urandom);
                bcd_in     = r >> (4 * $urandom_range(0, 6));
                dp_mask    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
                blink_mask = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
                upd        = 1'b1;
            end
            step();
            upd = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
